// File: rtl/exmem_skid_stage_if.sv
// Handshake and data bundle between EX, the EX->MEM skid stage and MEM.
// The stage attaches through the slave modport; the driving environment uses master.
interface exmem_skid_stage_if #(
  parameter int N     = 18,
  parameter int LANES = 3,
  parameter int RW    = 4
);
  logic                 flush;
  logic                 in_valid;
  logic                 in_ready;
  logic [LANES*N-1:0]   alu_result;
  logic [LANES*N-1:0]   mem_dir2;
  logic [LANES*N-1:0]   mem_dir3;
  logic [LANES*N-1:0]   write_data;
  logic [RW-1:0]        wa3;
  logic                 pc_src;
  logic                 reg_write;
  logic                 mem_to_reg;
  logic                 mem_write;
  logic                 out_valid;
  logic                 out_ready;
  logic [LANES*N-1:0]   q1;
  logic [LANES*N-1:0]   q2;
  logic [LANES*N-1:0]   q3;
  logic [LANES*N-1:0]   write_data_o;
  logic [RW-1:0]        wa3_o;
  logic                 pc_src_o;
  logic                 reg_write_o;
  logic                 mem_to_reg_o;
  logic                 mem_write_o;

  modport slave (
    input  flush, in_valid, alu_result, mem_dir2, mem_dir3, write_data, wa3,
           pc_src, reg_write, mem_to_reg, mem_write, out_ready,
    output in_ready, out_valid, q1, q2, q3, write_data_o, wa3_o,
           pc_src_o, reg_write_o, mem_to_reg_o, mem_write_o
  );

  modport master (
    output flush, in_valid, alu_result, mem_dir2, mem_dir3, write_data, wa3,
           pc_src, reg_write, mem_to_reg, mem_write, out_ready,
    input  in_ready, out_valid, q1, q2, q3, write_data_o, wa3_o,
           pc_src_o, reg_write_o, mem_to_reg_o, mem_write_o
  );
endinterface

// File: rtl/exmem_skid_stage.sv
// Elastic EX->MEM stage: two-entry valid/ready skid buffer with flush.
// Optional macro EXMEM_STALL_CNT_EN adds a saturating MEM back-pressure counter (stall_cnt).
module exmem_skid_stage #(
  parameter int N     = 18,
  parameter int LANES = 3,
  parameter int RW    = 4
) (
  input  logic              clk,
  input  logic              reset,
  exmem_skid_stage_if.slave bus
`ifdef EXMEM_STALL_CNT_EN
  ,
  output logic [31:0]       stall_cnt
`endif
);
  localparam int W = LANES * N;

  typedef struct packed {
    logic [W-1:0]  alu;
    logic [W-1:0]  dir2;
    logic [W-1:0]  dir3;
    logic [W-1:0]  wdata;
    logic [RW-1:0] wa3;
    logic          pc_src;
    logic          reg_write;
    logic          mem_to_reg;
    logic          mem_write;
  } beat_t;

  // Encoding is {main_valid, skid_valid}, so the valid bits fall straight out of the state.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b10,
    TWO   = 2'b11
  } state_t;

  state_t state;
  beat_t  main_q;
  beat_t  skid_q;
  beat_t  in_beat;
  logic   main_valid;
  logic   skid_valid;
  logic   push;
  logic   pop;

  assign main_valid = state[1];
  assign skid_valid = state[0];
  assign push       = bus.in_valid & ~skid_valid;
  assign pop        = main_valid & bus.out_ready;

  assign in_beat = '{
    alu:        bus.alu_result,
    dir2:       bus.mem_dir2,
    dir3:       bus.mem_dir3,
    wdata:      bus.write_data,
    wa3:        bus.wa3,
    pc_src:     bus.pc_src,
    reg_write:  bus.reg_write,
    mem_to_reg: bus.mem_to_reg,
    mem_write:  bus.mem_write
  };

  // Flush only clears valid bits; stale data stays behind the masked controls.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= EMPTY;
      main_q <= '0;
      skid_q <= '0;
    end else if (bus.flush) begin
      state <= EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (push) begin
            main_q <= in_beat;
            state  <= ONE;
          end
        end
        ONE: begin
          if (push && pop) begin
            main_q <= in_beat;
          end else if (push) begin
            skid_q <= in_beat;
            state  <= TWO;
          end else if (pop) begin
            state  <= EMPTY;
          end
        end
        TWO: begin
          if (pop) begin
            main_q <= skid_q;
            state  <= ONE;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

  assign bus.in_ready     = ~skid_valid;
  assign bus.out_valid    = main_valid;
  assign bus.q1           = main_q.alu;
  assign bus.q2           = main_q.dir2;
  assign bus.q3           = main_q.dir3;
  assign bus.write_data_o = main_q.wdata;
  assign bus.wa3_o        = main_q.wa3;
  assign bus.pc_src_o     = main_q.pc_src & main_valid;
  assign bus.reg_write_o  = main_q.reg_write & main_valid;
  assign bus.mem_to_reg_o = main_q.mem_to_reg & main_valid;
  assign bus.mem_write_o  = main_q.mem_write & main_valid;

`ifdef EXMEM_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (main_valid && !bus.out_ready && stall_cnt != 32'hFFFF_FFFF) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_exmem_skid_stage.sv
// Directed self-checking bench for exmem_skid_stage; covers the stall counter
// when EXMEM_STALL_CNT_EN is defined.
module tb_exmem_skid_stage;
  localparam int N     = 18;
  localparam int LANES = 3;
  localparam int RW    = 4;
  localparam int W     = LANES * N;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   total = 0;
  int   bad   = 0;
`ifdef EXMEM_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  exmem_skid_stage_if #(.N(N), .LANES(LANES), .RW(RW)) bus ();

  exmem_skid_stage #(.N(N), .LANES(LANES), .RW(RW)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus)
`ifdef EXMEM_STALL_CNT_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] pack3(input int l0, input int l1, input int l2);
    logic [N-1:0] a, b, c;
    a = N'(l0);
    b = N'(l1);
    c = N'(l2);
    return {c, b, a};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.flush      = 1'b0;
    bus.in_valid   = 1'b0;
    bus.out_ready  = 1'b0;
    bus.alu_result = '0;
    bus.mem_dir2   = '0;
    bus.mem_dir3   = '0;
    bus.write_data = '0;
    bus.wa3        = '0;
    bus.pc_src     = 1'b0;
    bus.reg_write  = 1'b0;
    bus.mem_to_reg = 1'b0;
    bus.mem_write  = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    step();
    step();
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("[TB] FAIL rst_out_valid got=%0b want=0", bus.out_valid); end
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("[TB] FAIL rst_in_ready got=%0b want=1", bus.in_ready); end
    total++; if (bus.q1 !== '0) begin bad++; $display("[TB] FAIL rst_q1 got=%h want=0", bus.q1); end
    total++; if (bus.wa3_o !== '0) begin bad++; $display("[TB] FAIL rst_wa3 got=%h want=0", bus.wa3_o); end
    total++; if (bus.mem_write_o !== 1'b0) begin bad++; $display("[TB] FAIL rst_mem_write got=%0b want=0", bus.mem_write_o); end
    reset = 1'b0;
  endtask

  task automatic test_single();
    bus.in_valid   = 1'b1;
    bus.out_ready  = 1'b1;
    bus.alu_result = pack3(1, 2, 3);
    bus.mem_dir2   = pack3(4, 5, 6);
    bus.mem_dir3   = pack3(7, 8, 9);
    bus.write_data = pack3(10, 11, 12);
    bus.wa3        = 4'd5;
    bus.pc_src     = 1'b1;
    bus.reg_write  = 1'b0;
    bus.mem_to_reg = 1'b1;
    bus.mem_write  = 1'b1;
    step();
    bus.in_valid = 1'b0;
    total++; if (bus.out_valid !== 1'b1) begin bad++; $display("[TB] FAIL single_valid got=%0b want=1", bus.out_valid); end
    total++; if (bus.q1 !== pack3(1, 2, 3)) begin bad++; $display("[TB] FAIL single_q1 got=%h want=%h", bus.q1, pack3(1, 2, 3)); end
    total++; if (bus.q2 !== pack3(4, 5, 6)) begin bad++; $display("[TB] FAIL single_q2 got=%h want=%h", bus.q2, pack3(4, 5, 6)); end
    total++; if (bus.q3 !== pack3(7, 8, 9)) begin bad++; $display("[TB] FAIL single_q3 got=%h want=%h", bus.q3, pack3(7, 8, 9)); end
    total++; if (bus.write_data_o !== pack3(10, 11, 12)) begin bad++; $display("[TB] FAIL single_wdata got=%h want=%h", bus.write_data_o, pack3(10, 11, 12)); end
    total++; if (bus.wa3_o !== 4'd5) begin bad++; $display("[TB] FAIL single_wa3 got=%0d want=5", bus.wa3_o); end
    total++; if ({bus.pc_src_o, bus.reg_write_o, bus.mem_to_reg_o, bus.mem_write_o} !== 4'b1011) begin
      bad++; $display("[TB] FAIL single_ctrl got=%b want=1011", {bus.pc_src_o, bus.reg_write_o, bus.mem_to_reg_o, bus.mem_write_o});
    end
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("[TB] FAIL single_in_ready got=%0b want=1", bus.in_ready); end
    step();
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("[TB] FAIL single_drain got=%0b want=0", bus.out_valid); end
    total++; if ({bus.pc_src_o, bus.mem_to_reg_o, bus.mem_write_o} !== 3'b000) begin
      bad++; $display("[TB] FAIL single_ctrl_mask got=%b want=000", {bus.pc_src_o, bus.mem_to_reg_o, bus.mem_write_o});
    end
  endtask

  task automatic test_back_to_back();
    idle_inputs();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus.in_valid   = 1'b1;
      bus.wa3        = RW'(i);
      bus.alu_result = pack3(i, i + 100, i + 200);
      step();
      total++; if (bus.out_valid !== 1'b1 || bus.wa3_o !== RW'(i)) begin
        bad++; $display("[TB] FAIL stream_%0d got valid=%0b wa3=%0d want valid=1 wa3=%0d", i, bus.out_valid, bus.wa3_o, i);
      end
      total++; if (bus.q1 !== pack3(i, i + 100, i + 200)) begin
        bad++; $display("[TB] FAIL stream_q1_%0d got=%h want=%h", i, bus.q1, pack3(i, i + 100, i + 200));
      end
    end
    bus.in_valid = 1'b0;
    step();
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("[TB] FAIL stream_end got=%0b want=0", bus.out_valid); end
  endtask

  task automatic test_backpressure();
    idle_inputs();
    bus.in_valid   = 1'b1;
    bus.wa3        = 4'd10;
    bus.write_data = pack3(10, 10, 10);
    step();
    total++; if (bus.in_ready !== 1'b1 || bus.wa3_o !== 4'd10) begin
      bad++; $display("[TB] FAIL bp_a got ready=%0b wa3=%0d want ready=1 wa3=10", bus.in_ready, bus.wa3_o);
    end
    bus.wa3        = 4'd11;
    bus.write_data = pack3(11, 11, 11);
    step();
    total++; if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || bus.wa3_o !== 4'd10) begin
      bad++; $display("[TB] FAIL bp_full got ready=%0b valid=%0b wa3=%0d want ready=0 valid=1 wa3=10", bus.in_ready, bus.out_valid, bus.wa3_o);
    end
    bus.wa3        = 4'd12;
    bus.write_data = pack3(12, 12, 12);
    step();
    total++; if (bus.in_ready !== 1'b0 || bus.wa3_o !== 4'd10 || bus.write_data_o !== pack3(10, 10, 10)) begin
      bad++; $display("[TB] FAIL bp_hold got ready=%0b wa3=%0d want ready=0 wa3=10", bus.in_ready, bus.wa3_o);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    step();
    total++; if (bus.out_valid !== 1'b1 || bus.wa3_o !== 4'd11 || bus.in_ready !== 1'b1) begin
      bad++; $display("[TB] FAIL bp_b got valid=%0b wa3=%0d ready=%0b want valid=1 wa3=11 ready=1", bus.out_valid, bus.wa3_o, bus.in_ready);
    end
    total++; if (bus.write_data_o !== pack3(11, 11, 11)) begin
      bad++; $display("[TB] FAIL bp_b_data got=%h want=%h", bus.write_data_o, pack3(11, 11, 11));
    end
    step();
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("[TB] FAIL bp_drain got=%0b want=0", bus.out_valid); end
  endtask

  task automatic test_flush();
    idle_inputs();
    bus.in_valid  = 1'b1;
    bus.mem_write = 1'b1;
    bus.reg_write = 1'b1;
    bus.pc_src    = 1'b1;
    bus.wa3       = 4'd1;
    step();
    bus.wa3 = 4'd2;
    step();
    total++; if (bus.in_ready !== 1'b0) begin bad++; $display("[TB] FAIL flush_pre got=%0b want=0", bus.in_ready); end
    bus.flush = 1'b1;
    bus.wa3   = 4'd3;
    step();
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    total++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      bad++; $display("[TB] FAIL flush_two got valid=%0b ready=%0b want valid=0 ready=1", bus.out_valid, bus.in_ready);
    end
    total++; if ({bus.pc_src_o, bus.reg_write_o, bus.mem_to_reg_o, bus.mem_write_o} !== 4'b0000) begin
      bad++; $display("[TB] FAIL flush_ctrl got=%b want=0000", {bus.pc_src_o, bus.reg_write_o, bus.mem_to_reg_o, bus.mem_write_o});
    end
    bus.out_ready = 1'b1;
    step();
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("[TB] FAIL flush_ghost got=%0b want=0", bus.out_valid); end
    bus.flush    = 1'b1;
    bus.in_valid = 1'b1;
    bus.wa3      = 4'd4;
    step();
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    total++; if (bus.out_valid !== 1'b0 || bus.mem_write_o !== 1'b0) begin
      bad++; $display("[TB] FAIL flush_drop got valid=%0b mw=%0b want 0 0", bus.out_valid, bus.mem_write_o);
    end
  endtask

  task automatic test_reset_in_two();
    idle_inputs();
    bus.in_valid   = 1'b1;
    bus.mem_write  = 1'b1;
    bus.wa3        = 4'd7;
    bus.alu_result = pack3(5, 6, 7);
    bus.write_data = pack3(9, 9, 9);
    step();
    step();
    bus.in_valid = 1'b0;
    total++; if (bus.in_ready !== 1'b0 || bus.mem_write_o !== 1'b1) begin
      bad++; $display("[TB] FAIL rst2_pre got ready=%0b mw=%0b want ready=0 mw=1", bus.in_ready, bus.mem_write_o);
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    total++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.mem_write_o !== 1'b0) begin
      bad++; $display("[TB] FAIL rst2_state got valid=%0b ready=%0b mw=%0b want 0 1 0", bus.out_valid, bus.in_ready, bus.mem_write_o);
    end
    total++; if (bus.q1 !== '0 || bus.write_data_o !== '0 || bus.wa3_o !== '0) begin
      bad++; $display("[TB] FAIL rst2_data got q1=%h wd=%h wa3=%0d want all 0", bus.q1, bus.write_data_o, bus.wa3_o);
    end
    bus.out_ready = 1'b1;
    step();
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("[TB] FAIL rst2_skid got=%0b want=0", bus.out_valid); end
  endtask

`ifdef EXMEM_STALL_CNT_EN
  task automatic test_stall_cnt();
    idle_inputs();
    reset = 1'b1;
    step();
    reset = 1'b0;
    total++; if (stall_cnt !== 32'd0) begin bad++; $display("[TB] FAIL stall_rst got=%0d want=0", stall_cnt); end
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    for (int i = 0; i < 5; i++) step();
    total++; if (stall_cnt !== 32'd5) begin bad++; $display("[TB] FAIL stall_five got=%0d want=5", stall_cnt); end
    bus.flush     = 1'b1;
    bus.out_ready = 1'b1;
    step();
    bus.flush = 1'b0;
    step();
    total++; if (stall_cnt !== 32'd5 || bus.out_valid !== 1'b0) begin
      bad++; $display("[TB] FAIL stall_flush got=%0d valid=%0b want 5 0", stall_cnt, bus.out_valid);
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    total++; if (stall_cnt !== 32'd0) begin bad++; $display("[TB] FAIL stall_clear got=%0d want=0", stall_cnt); end
  endtask
`endif

  initial begin
    idle_inputs();
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_reset_in_two();
`ifdef EXMEM_STALL_CNT_EN
    test_stall_cnt();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
